asi_spram: RTL and testbench
============================

// Module: asi_spram
// PURPOSE
//  Single-port, byte-writable SRAM slave sitting directly downstream of the AXI slave interface usr_* port.
//  Consumes usr_a/usr_ce/usr_d/usr_we and returns read data on usr_q exactly SLV_WS cycles after a read strobe.
//  Reports unsupported transfer sizes back to the interface on usr_wsize_error/usr_rsize_error.
//  Used as the default memory model under the interface and as the synthesizable scratchpad behind it.
// PARAMETERS
//  AXI_DW      128                 data width; multiple of 8
//  AXI_AW      40                  usr_a width (byte address)
//  AXI_SW      3                   usr_wsize/usr_rsize width
//  AXI_WSTRBW  AXI_DW/8            usr_we width, one bit per byte lane
//  MEM_AW      10                  word-address bits; depth = 2**MEM_AW words of AXI_DW
//  SLV_WS      1                   read latency in cycles, legal range 1..8
//  SLV_MAXSIZE $clog2(AXI_DW/8)    largest supported AxSIZE encoding
// PORTS
//  usr_clk          in   1           clock; all state on rising edge
//  usr_reset        in   1           synchronous, active-high reset
//  usr_a            in   AXI_AW      byte address
//  usr_ce           in   1           access strobe, active-high
//  usr_d            in   AXI_DW      write data
//  usr_we           in   AXI_WSTRBW  per-byte write enable, active-high
//  usr_q            out  AXI_DW      read data
//  usr_q_valid      out  1           1-cycle pulse when usr_q updates (verification aid)
//  usr_wsize        in   AXI_SW      current write burst size
//  usr_rsize        in   AXI_SW      current read burst size
//  usr_wsize_error  out  1           usr_wsize unsupported
//  usr_rsize_error  out  1           usr_rsize unsupported
// BEHAVIOUR
//  - Decode: LSB = $clog2(AXI_DW/8); word index = usr_a[LSB+MEM_AW-1:LSB].
//    in_range = (usr_a[AXI_AW-1:LSB+MEM_AW] == 0).
//  - Write: usr_ce & |usr_we. At the edge, memory[idx] byte k <= usr_d byte k for each usr_we[k]=1.
//    Other bytes are unchanged. Out-of-range writes are dropped silently.
//  - Read: usr_ce & ~|usr_we. Launches a read of memory[idx] into a SLV_WS-deep pipeline (valid bit + data per stage).
//    Out-of-range reads return all-zero data. Reads may issue back-to-back, one per cycle, with no bubbles.
//  - Read output: usr_q is a register. For a read issued at the edge of cycle N, usr_q holds the data and
//    usr_q_valid=1 during cycle N+SLV_WS. Between reads, usr_q holds the last returned value and usr_q_valid=0.
//  - Ordering: a write at cycle N followed by a read of the same word at cycle N+1 returns the new data.
//    No forwarding is needed, because the array is updated at edge N.
//  - usr_ce=0: no access; usr_we is ignored.
//  - Size errors are combinational: usr_wsize_error = (usr_wsize > SLV_MAXSIZE); same rule for read.
//    Both outputs are independent of usr_ce and of reset.
//  - Reset (synchronous, usr_reset=1 at an edge):
//    usr_q <= 0, usr_q_valid <= 0, all pipeline valid bits <= 0.
//    In-flight reads are discarded and never produce usr_q_valid.
//    Memory contents are not reset.
//    An access presented while usr_reset=1 is ignored: no write, no read launch.
//  - Latency is fixed at SLV_WS and does not depend on address range or prior traffic.
// TESTING
//  1. Reset, then write 0x00..0F pattern to word 3 (usr_a=0x30, usr_we=all 1s), then read 0x30
//     -> usr_q = pattern exactly SLV_WS cycles later with usr_q_valid=1 for 1 cycle.
//  2. Write 0xFF.. to word 5, then write 0x00.. with usr_we=16'h00F0, then read
//     -> bytes 4-7 = 0x00, all other bytes 0xFF.
//  3. Back-to-back reads of words 0,1,2,3 over 4 cycles (SLV_WS=1 and SLV_WS=3)
//     -> 4 consecutive usr_q_valid pulses carrying the data in order.
//  4. Write then read at address 1<<(LSB+MEM_AW)
//     -> write dropped (word 0 unchanged), read returns 0 with usr_q_valid.
//  5. usr_wsize=3'd5, usr_rsize=3'd4 with AXI_DW=128
//     -> usr_wsize_error=1, usr_rsize_error=0; usr_rsize=3'd4 -> no error.
//  6. Issue a read, assert usr_reset in the following cycle (SLV_WS=3)
//     -> no usr_q_valid, usr_q=0; memory intact on a later read.

Source files
------------

// File: rtl/asi_spram_if.sv
// usr_* port bundle between the AXI slave interface (master side) and the SRAM slave.
// Carries the access strobe, address, write data/strobes, read return and size-error flags.
interface asi_spram_if #(
   parameter int unsigned AXI_DW = 128,
   parameter int unsigned AXI_AW = 40,
   parameter int unsigned AXI_SW = 3
);
   localparam int unsigned AXI_WSTRBW = AXI_DW / 8;

   logic [AXI_AW-1:0]     usr_a;
   logic                  usr_ce;
   logic [AXI_DW-1:0]     usr_d;
   logic [AXI_WSTRBW-1:0] usr_we;
   logic [AXI_DW-1:0]     usr_q;
   logic                  usr_q_valid;
   logic [AXI_SW-1:0]     usr_wsize;
   logic [AXI_SW-1:0]     usr_rsize;
   logic                  usr_wsize_error;
   logic                  usr_rsize_error;

   modport master (
      output usr_a, usr_ce, usr_d, usr_we, usr_wsize, usr_rsize,
      input  usr_q, usr_q_valid, usr_wsize_error, usr_rsize_error
   );

   modport slave (
      input  usr_a, usr_ce, usr_d, usr_we, usr_wsize, usr_rsize,
      output usr_q, usr_q_valid, usr_wsize_error, usr_rsize_error
   );
endinterface

// File: rtl/asi_spram.sv
// Single-port byte-writable SRAM slave behind the AXI slave usr_* port.
// Reads return after a fixed SLV_WS cycles; unsupported AxSIZE values are flagged combinationally.
module asi_spram #(
   parameter int unsigned AXI_DW      = 128,
   parameter int unsigned AXI_AW      = 40,
   parameter int unsigned AXI_SW      = 3,
   parameter int unsigned AXI_WSTRBW  = AXI_DW / 8,
   parameter int unsigned MEM_AW      = 10,
   parameter int unsigned SLV_WS      = 1,
   parameter int unsigned SLV_MAXSIZE = $clog2(AXI_DW / 8)
) (
   input logic        usr_clk,
   input logic        usr_reset,
   asi_spram_if.slave usr
);
   localparam int unsigned LSB   = $clog2(AXI_DW / 8);
   localparam int unsigned Depth = 2 ** MEM_AW;

   logic [AXI_DW-1:0] mem_q [Depth];

   logic [MEM_AW-1:0] idx;
   logic              in_range;
   logic              rd_go;
   logic              wr_go;
   logic [AXI_DW-1:0] rdata;
   logic              unused_a;

   // Read pipeline: stage i is fed by in_v/in_d[i]; the last stage is usr_q itself.
   logic [SLV_WS-1:0] vld_q, vld_d;
   logic [SLV_WS-1:0] in_v;
   logic [AXI_DW-1:0] in_d  [SLV_WS];
   logic [AXI_DW-1:0] dat_q [SLV_WS];
   logic [AXI_DW-1:0] dat_d [SLV_WS];

   assign idx      = usr.usr_a[LSB+MEM_AW-1:LSB];
   assign in_range = (usr.usr_a[AXI_AW-1:LSB+MEM_AW] == '0);
   assign unused_a = ^usr.usr_a[LSB-1:0];

   // Accesses presented during reset are dropped entirely.
   assign wr_go = ~usr_reset & usr.usr_ce & (|usr.usr_we);
   assign rd_go = ~usr_reset & usr.usr_ce & ~(|usr.usr_we);
   assign rdata = in_range ? mem_q[idx] : '0;

   always_ff @(posedge usr_clk) begin
      if (wr_go && in_range) begin
         for (int k = 0; k < AXI_WSTRBW; k++) begin
            if (usr.usr_we[k]) begin
               mem_q[idx][8*k +: 8] <= usr.usr_d[8*k +: 8];
            end
         end
      end
   end

   for (genvar i = 0; i < SLV_WS; i++) begin : g_stage
      if (i == 0) begin : g_first
         assign in_v[i] = rd_go;
         assign in_d[i] = rdata;
      end else begin : g_next
         assign in_v[i] = vld_q[i-1];
         assign in_d[i] = dat_q[i-1];
      end
   end

   // Data only moves with a valid token, so usr_q holds the last return between reads.
   always_comb begin
      vld_d = in_v;
      for (int i = 0; i < SLV_WS; i++) begin
         dat_d[i] = dat_q[i];
         if (in_v[i]) begin
            dat_d[i] = in_d[i];
         end
      end
   end

   always_ff @(posedge usr_clk) begin
      if (usr_reset) begin
         vld_q <= '0;
         for (int i = 0; i < SLV_WS; i++) begin
            dat_q[i] <= '0;
         end
      end else begin
         vld_q <= vld_d;
         dat_q <= dat_d;
      end
   end

   assign usr.usr_q       = dat_q[SLV_WS-1];
   assign usr.usr_q_valid = vld_q[SLV_WS-1];

   assign usr.usr_wsize_error = (32'(usr.usr_wsize) > SLV_MAXSIZE);
   assign usr.usr_rsize_error = (32'(usr.usr_rsize) > SLV_MAXSIZE);
endmodule

// File: tb/tb_asi_spram.sv
// Bench for asi_spram: drives a SLV_WS=1 and a SLV_WS=3 instance with identical traffic
// and compares both against a queue-based reference model every cycle.
module tb_asi_spram;
   localparam int unsigned DW  = 128;
   localparam int unsigned AW  = 40;
   localparam int unsigned MAW = 10;

   typedef struct packed {
      int           due;
      logic [127:0] dat;
   } pend_t;

   typedef struct packed {
      logic [2:0] wsize;
      logic [2:0] rsize;
      logic       exp_werr;
      logic       exp_rerr;
   } size_vec_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   asi_spram_if #(.AXI_DW(DW), .AXI_AW(AW), .AXI_SW(3)) if1 ();
   asi_spram_if #(.AXI_DW(DW), .AXI_AW(AW), .AXI_SW(3)) if3 ();

   asi_spram #(.AXI_DW(DW), .AXI_AW(AW), .AXI_SW(3), .MEM_AW(MAW), .SLV_WS(1)) u_ws1 (
      .usr_clk   (clk),
      .usr_reset (rst),
      .usr       (if1)
   );

   asi_spram #(.AXI_DW(DW), .AXI_AW(AW), .AXI_SW(3), .MEM_AW(MAW), .SLV_WS(3)) u_ws3 (
      .usr_clk   (clk),
      .usr_reset (rst),
      .usr       (if3)
   );

   int n_chk  = 0;
   int n_pass = 0;

   // Reference model state
   logic [127:0] ref_mem [int];
   pend_t        pq1 [$];
   pend_t        pq3 [$];
   logic [127:0] eq1, eq3;
   logic         ev1, ev3;
   int           ecnt = 0;

   task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", nm, got, exp);
   endtask

   // One clock edge of the behavioural model, fed the values sampled at that edge.
   task automatic model(input logic r, input logic c, input logic [39:0] a,
                        input logic [15:0] we, input logic [127:0] d);
      logic         inr;
      int           idx;
      logic [127:0] rdat;
      logic [127:0] tmp;
      inr = (a[39:14] == '0);
      idx = int'(a[13:4]);
      if (r) begin
         pq1.delete();
         pq3.delete();
         eq1 = '0;
         eq3 = '0;
         ev1 = 1'b0;
         ev3 = 1'b0;
      end else begin
         ev1 = 1'b0;
         ev3 = 1'b0;
         if (c && we == '0) begin
            rdat = inr ? ref_mem[idx] : '0;
            pq1.push_back('{due: ecnt, dat: rdat});
            pq3.push_back('{due: ecnt + 2, dat: rdat});
         end
         if (pq1.size() > 0 && pq1[0].due == ecnt) begin
            eq1 = pq1[0].dat;
            ev1 = 1'b1;
            void'(pq1.pop_front());
         end
         if (pq3.size() > 0 && pq3[0].due == ecnt) begin
            eq3 = pq3[0].dat;
            ev3 = 1'b1;
            void'(pq3.pop_front());
         end
         if (c && we != '0 && inr) begin
            tmp = ref_mem.exists(idx) ? ref_mem[idx] : 'x;
            for (int k = 0; k < 16; k++) begin
               if (we[k]) tmp[8*k +: 8] = d[8*k +: 8];
            end
            ref_mem[idx] = tmp;
         end
      end
      ecnt++;
   endtask

   task automatic step(input logic r, input logic c, input logic [39:0] a,
                       input logic [15:0] we, input logic [127:0] d);
      rst        = r;
      if1.usr_ce = c;
      if1.usr_a  = a;
      if1.usr_we = we;
      if1.usr_d  = d;
      if3.usr_ce = c;
      if3.usr_a  = a;
      if3.usr_we = we;
      if3.usr_d  = d;
      @(posedge clk);
      model(r, c, a, we, d);
      #1;
      chk("ws1_valid", 128'(if1.usr_q_valid), 128'(ev1));
      chk("ws1_q", if1.usr_q, eq1);
      chk("ws3_valid", 128'(if3.usr_q_valid), 128'(ev3));
      chk("ws3_q", if3.usr_q, eq3);
   endtask

   task automatic idle();
      step(1'b0, 1'b0, '0, '0, '0);
   endtask

   task automatic wr(input logic [39:0] a, input logic [15:0] we, input logic [127:0] d);
      step(1'b0, 1'b1, a, we, d);
   endtask

   // Read with a hand-computed expectation, checked at the return cycle of each instance.
   task automatic expect_read(input string nm, input logic [39:0] a, input logic [127:0] exp);
      step(1'b0, 1'b1, a, '0, '0);
      chk({nm, "_ws1_v"}, 128'(if1.usr_q_valid), 128'(1));
      chk({nm, "_ws1_q"}, if1.usr_q, exp);
      idle();
      idle();
      chk({nm, "_ws3_v"}, 128'(if3.usr_q_valid), 128'(1));
      chk({nm, "_ws3_q"}, if3.usr_q, exp);
      idle();
   endtask

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   size_vec_t    svec [6];
   logic [127:0] pat, k0, k7, w5;
   logic [39:0]  ra;
   int           op;

   initial begin
      svec[0] = '{wsize: 3'd5, rsize: 3'd4, exp_werr: 1'b1, exp_rerr: 1'b0};
      svec[1] = '{wsize: 3'd4, rsize: 3'd4, exp_werr: 1'b0, exp_rerr: 1'b0};
      svec[2] = '{wsize: 3'd0, rsize: 3'd7, exp_werr: 1'b0, exp_rerr: 1'b1};
      svec[3] = '{wsize: 3'd7, rsize: 3'd0, exp_werr: 1'b1, exp_rerr: 1'b0};
      svec[4] = '{wsize: 3'd3, rsize: 3'd5, exp_werr: 1'b0, exp_rerr: 1'b1};
      svec[5] = '{wsize: 3'd6, rsize: 3'd6, exp_werr: 1'b1, exp_rerr: 1'b1};

      if1.usr_wsize = '0;
      if1.usr_rsize = '0;
      if3.usr_wsize = '0;
      if3.usr_rsize = '0;

      step(1'b1, 1'b0, '0, '0, '0);
      step(1'b1, 1'b0, '0, '0, '0);

      // Size errors are combinational and independent of reset/strobe
      for (int i = 0; i < 6; i++) begin
         if1.usr_wsize = svec[i].wsize;
         if1.usr_rsize = svec[i].rsize;
         if3.usr_wsize = svec[i].wsize;
         if3.usr_rsize = svec[i].rsize;
         #1;
         chk($sformatf("size%0d_werr", i), 128'(if1.usr_wsize_error), 128'(svec[i].exp_werr));
         chk($sformatf("size%0d_rerr", i), 128'(if1.usr_rsize_error), 128'(svec[i].exp_rerr));
         chk($sformatf("size%0d_werr3", i), 128'(if3.usr_wsize_error), 128'(svec[i].exp_werr));
      end
      if1.usr_wsize = '0;
      if1.usr_rsize = '0;
      if3.usr_wsize = '0;
      if3.usr_rsize = '0;

      // Give every word the random traffic touches a known value
      for (int w = 0; w < 16; w++) wr(40'(w * 16), 16'hFFFF, rnd128());

      for (int k = 0; k < 16; k++) pat[8*k +: 8] = 8'(k);
      wr(40'h30, 16'hFFFF, pat);
      expect_read("t1", 40'h30, pat);

      wr(40'h50, 16'hFFFF, {128{1'b1}});
      wr(40'h50, 16'h00F0, '0);
      w5 = 128'hFFFFFFFF_FFFFFFFF_00000000_FFFFFFFF;
      expect_read("t2", 40'h50, w5);

      for (int w = 0; w < 4; w++) step(1'b0, 1'b1, 40'(w * 16), '0, '0);
      idle();
      idle();
      idle();

      k0 = rnd128();
      wr(40'h0, 16'hFFFF, k0);
      wr(40'h4000, 16'hFFFF, ~k0);
      expect_read("t4_oor", 40'h4000, '0);
      expect_read("t4_w0", 40'h0, k0);

      k7 = rnd128();
      wr(40'h70, 16'hFFFF, k7);
      step(1'b0, 1'b1, 40'h50, '0, '0);
      step(1'b1, 1'b1, 40'h70, 16'hFFFF, ~k7);
      chk("t6_rst_q", if3.usr_q, '0);
      idle();
      idle();
      chk("t6_after_v", 128'(if3.usr_q_valid), 128'(0));
      chk("t6_after_q", if3.usr_q, '0);
      expect_read("t6_w5", 40'h50, w5);
      expect_read("t6_w7", 40'h70, k7);

      for (int n = 0; n < 600; n++) begin
         op = int'($urandom_range(0, 9));
         ra = 40'(($urandom_range(0, 15) * 16) + $urandom_range(0, 15));
         if (op == 7 || op == 8) ra = ra | (40'($urandom_range(1, 255)) << 14);
         case (op)
            0, 1:    idle();
            2, 3, 4: step(1'b0, 1'b1, ra, '0, '0);
            5, 6, 8: wr(ra, 16'($urandom), rnd128());
            7:       step(1'b0, 1'b1, ra, '0, '0);
            default: step($urandom_range(0, 4) == 0, 1'b1, ra, 16'($urandom_range(0, 1)), rnd128());
         endcase
      end
      idle();
      idle();
      idle();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
